// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz raster constants and coordinate type
package vga_timing_pkg;
    typedef logic [9:0] coord_t;
    localparam coord_t H_VISIBLE    = 10'd640;
    localparam coord_t H_FP         = 10'd16;
    localparam coord_t H_SYNC       = 10'd96;
    localparam coord_t H_BP         = 10'd48;
    localparam coord_t H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam coord_t V_VISIBLE    = 10'd480;
    localparam coord_t V_FP         = 10'd10;
    localparam coord_t V_SYNC       = 10'd2;
    localparam coord_t V_BP         = 10'd33;
    localparam coord_t V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_SYNC_START = H_VISIBLE + H_FP;
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
    localparam coord_t V_SYNC_START = V_VISIBLE + V_FP;
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;
endpackage

// File: rtl/vga_scan_gen_if.sv
// vga_scan_gen_if: raster position, syncs and sprite address towards the renderers
interface vga_scan_gen_if;
    import vga_timing_pkg::*;
    coord_t     DrawX;
    coord_t     DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       frame_start;
    logic [9:0] rom_address;
    logic       hs_d;
    logic       vs_d;
    logic       blank_d;
    modport master (output DrawX, DrawY, blank, hs, vs, frame_start, rom_address, hs_d, vs_d, blank_d);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, rom_address, hs_d, vs_d, blank_d);
endinterface

// File: rtl/sync_delay.sv
// sync_delay: N-stage shift register aligning {hs, vs, blank} with registered colour
module sync_delay #(
    parameter int N = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [2:0] din,
    output logic [2:0] dout
);
    logic [2:0] sr [N];
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) sr[i] <= 3'b110;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
    end
    assign dout = sr[N-1];
endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 Hz raster counters, syncs and stretched 32x32 sprite address
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int PIPE_DLY = 1,
    parameter int TEX_W    = 32,
    parameter int TEX_H    = 32
) (
    input  logic      vga_clk,
    input  logic      reset_n,
    vga_scan_gen_if.master vga
);
    localparam coord_t H_LAST     = H_TOTAL - 10'd1;
    localparam coord_t V_LAST     = V_TOTAL - 10'd1;
    localparam coord_t SUB_X_LAST = coord_t'(int'(H_VISIBLE) / TEX_W - 1);
    localparam coord_t SUB_Y_LAST = coord_t'(int'(V_VISIBLE) / TEX_H - 1);

    coord_t     x, y, nx, ny, sub_x, sub_y;
    logic [4:0] tex_x, tex_y;
    logic       line_wrap, frame_wrap, hs, vs, blank, frame_start;

    always_comb begin
        line_wrap  = x == H_LAST;
        frame_wrap = line_wrap && y == V_LAST;
        nx         = line_wrap ? '0 : x + 10'd1;
        ny         = frame_wrap ? '0 : line_wrap ? y + 10'd1 : y;
    end

    // Syncs are decoded from the next position so they line up with x/y.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x           <= H_LAST;
            y           <= V_LAST;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            sub_x       <= '0;
            sub_y       <= '0;
            tex_x       <= '0;
            tex_y       <= '0;
        end else begin
            x           <= nx;
            y           <= ny;
            hs          <= !(nx >= H_SYNC_START && nx <= H_SYNC_END);
            vs          <= !(ny >= V_SYNC_START && ny <= V_SYNC_END);
            blank       <= nx < H_VISIBLE && ny < V_VISIBLE;
            frame_start <= nx == '0 && ny == '0;
            if (line_wrap) begin
                sub_x <= '0;
                tex_x <= '0;
            end else if (x < H_VISIBLE - 10'd1 && y < V_VISIBLE) begin
                sub_x <= sub_x == SUB_X_LAST ? '0 : sub_x + 10'd1;
                tex_x <= sub_x == SUB_X_LAST ? tex_x + 5'd1 : tex_x;
            end
            if (frame_wrap) begin
                sub_y <= '0;
                tex_y <= '0;
            end else if (line_wrap && y < V_VISIBLE - 10'd1) begin
                sub_y <= sub_y == SUB_Y_LAST ? '0 : sub_y + 10'd1;
                tex_y <= sub_y == SUB_Y_LAST ? tex_y + 5'd1 : tex_y;
            end
        end
    end

    sync_delay #(.N(PIPE_DLY)) u_sync_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .din     ({hs, vs, blank}),
        .dout    ({vga.hs_d, vga.vs_d, vga.blank_d})
    );

    assign vga.DrawX       = x;
    assign vga.DrawY       = y;
    assign vga.hs          = hs;
    assign vga.vs          = vs;
    assign vga.blank       = blank;
    assign vga.frame_start = frame_start;
    assign vga.rom_address = blank ? {tex_y, tex_x} : '0;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed checks of raster timing, sprite address and delayed syncs
module tb_vga_scan_gen;
    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   ex, ey;
    logic [2:0] hist [4];
    logic [2:0] s;

    vga_scan_gen_if v1 ();
    vga_scan_gen_if v3 ();

    vga_scan_gen #(.PIPE_DLY(1)) u1 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(v1));
    vga_scan_gen #(.PIPE_DLY(3)) u3 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(v3));

    always #20 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [2:0] exp_sync(input int x, input int y);
        return {!(x >= 656 && x <= 751), !(y >= 490 && y <= 491), x < 640 && y < 480};
    endfunction

    function automatic int exp_rom(input int x, input int y);
        return (x < 640 && y < 480) ? (x * 32) / 640 + ((y * 32) / 480) * 32 : 0;
    endfunction

    task automatic step_model();
        ex = ex == 799 ? 0 : ex + 1;
        if (ex == 0) ey = ey == 524 ? 0 : ey + 1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"},     v1.DrawX, 799);
        chk({tag, "_y"},     v1.DrawY, 524);
        chk({tag, "_hs"},    v1.hs, 1);
        chk({tag, "_vs"},    v1.vs, 1);
        chk({tag, "_blank"}, v1.blank, 0);
        chk({tag, "_fs"},    v1.frame_start, 0);
        chk({tag, "_rom"},   v1.rom_address, 0);
        chk({tag, "_hs_d"},  v1.hs_d, 1);
        chk({tag, "_vs_d"},  v1.vs_d, 1);
        chk({tag, "_bl_d"},  v1.blank_d, 0);
        chk({tag, "_bl_d3"}, v3.blank_d, 0);
    endtask

    int sx [7] = '{19, 20, 639, 0, 0, 639, 640};
    int sy [7] = '{0, 0, 0, 14, 15, 479, 0};
    int sa [7] = '{0, 1, 31, 0, 32, 1023, 0};

    initial begin
        int err_pos = 0, err_sync = 0, err_rom = 0, err_d1 = 0, err_d3 = 0;
        int hs_low0 = 0, hs_first = -1, blank0 = 0, vs_low = 0, vs_first = -1;
        int fs_cnt = 0, fs_last = -1, line2 = -1;
        repeat (5) @(negedge vga_clk);
        chk_reset("rst");
        reset_n = 1'b1;
        @(negedge vga_clk);
        chk("first_x", v1.DrawX, 0);
        chk("first_y", v1.DrawY, 0);
        chk("first_blank", v1.blank, 1);
        chk("first_fs", v1.frame_start, 1);
        chk("first_rom", v1.rom_address, 0);
        ex = 0;
        ey = 0;
        for (int k = 0; k < 4; k++) hist[k] = 3'b110;
        for (int i = 0; i <= 420000; i++) begin
            s = exp_sync(ex, ey);
            for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = s;
            if (int'(v1.DrawX) != ex || int'(v1.DrawY) != ey || int'(v3.DrawX) != ex || int'(v3.DrawY) != ey) err_pos++;
            if ({v1.hs, v1.vs, v1.blank} !== s || {v3.hs, v3.vs, v3.blank} !== s || v1.frame_start !== (ex == 0 && ey == 0)) err_sync++;
            if (int'(v1.rom_address) != exp_rom(ex, ey) || int'(v3.rom_address) != exp_rom(ex, ey)) err_rom++;
            if ({v1.hs_d, v1.vs_d, v1.blank_d} !== hist[1]) err_d1++;
            if ({v3.hs_d, v3.vs_d, v3.blank_d} !== hist[3]) err_d3++;
            if (i < 800) begin
                if (!v1.hs) begin
                    hs_low0++;
                    if (hs_first < 0) hs_first = int'(v1.DrawX);
                end
                if (v1.blank) blank0++;
            end
            if (i < 420000 && !v1.vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(v1.DrawY);
            end
            if (v1.frame_start) begin
                fs_cnt++;
                fs_last = i;
            end
            if (i > 0 && line2 < 0 && v1.DrawX == 10'd0) line2 = i;
            for (int k = 0; k < 7; k++)
                if (ex == sx[k] && ey == sy[k])
                    chk($sformatf("rom_%0d_%0d", sx[k], sy[k]), v1.rom_address, sa[k]);
            @(negedge vga_clk);
            step_model();
        end
        chk("sweep_pos", err_pos, 0);
        chk("sweep_sync", err_sync, 0);
        chk("sweep_rom", err_rom, 0);
        chk("sweep_dly1", err_d1, 0);
        chk("sweep_dly3", err_d3, 0);
        chk("hs_low_len", hs_low0, 96);
        chk("hs_low_start", hs_first, 656);
        chk("blank_len", blank0, 640);
        chk("line_len", line2, 800);
        chk("vs_low_len", vs_low, 1600);
        chk("vs_low_start", vs_first, 490);
        chk("fs_count", fs_cnt, 2);
        chk("fs_period", fs_last, 420000);
        while (!(ex == 300 && ey == 200)) begin
            @(negedge vga_clk);
            step_model();
        end
        chk("pre_rst_x", v1.DrawX, 300);
        chk("pre_rst_y", v1.DrawY, 200);
        chk("pre_rst_bl_d", v1.blank_d, 1);
        #5 reset_n = 1'b0;
        #1 chk_reset("async_rst");
        repeat (2) @(negedge vga_clk);
        chk_reset("held_rst");
        reset_n = 1'b1;
        @(negedge vga_clk);
        chk("rel_x", v1.DrawX, 0);
        chk("rel_y", v1.DrawY, 0);
        chk("rel_fs", v1.frame_start, 1);
        chk("rel_blank", v1.blank, 1);
        chk("rel_rom", v1.rom_address, 0);
        repeat (20) @(negedge vga_clk);
        chk("rel_x20", v1.DrawX, 20);
        chk("rel_rom20", v1.rom_address, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
